// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM line and recovers the duty code.
// Latency: edge seen 3 cycles after the pin (3+FILT_LEN with PWM_CAP_FILTER_EN); results 1 cycle after the closing rise.
// Backpressure: none; meas_valid is a 1-cycle strobe. Optional glitch filter is enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
  parameter int CBITS     = 17,
  parameter int CODE_BITS = 3
`ifdef PWM_CAP_FILTER_EN
  ,parameter int FILT_LEN = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pulse_in,
  output logic [CBITS:0]       high_out,
  output logic [CBITS:0]       period_out,
  output logic                 meas_valid,
  output logic [CODE_BITS-1:0] code_out,
  output logic                 locked,
  output logic                 stuck_hi,
  output logic                 stuck_lo
);

  // Counter saturation value and the nominal generator period.
  localparam logic [CBITS:0] CNT_MAX = '1;
  localparam logic [CBITS:0] NOMINAL = {1'b1, {CBITS{1'b0}}};

  typedef enum logic [1:0] {
    S_WAIT,
    S_HIGH,
    S_LOW
  } state_t;

  state_t         state;
  logic           sync1;
  logic           sync2;
  logic           lvl;
  logic           prev;
  logic           rise;
  logic           fall;
  logic [CBITS:0] cnt;
  logic [CBITS:0] hi_cnt;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int RUN_W = $clog2(FILT_LEN + 1);

  logic             filt;
  logic [RUN_W-1:0] run;

  // Glitch filter: accept a new level only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (sync2 == filt) begin
      run <= '0;
    end else if (run == RUN_W'(FILT_LEN - 1)) begin
      filt <= sync2;
      run  <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  // Edge-detect register; its output is also the current line level used for the stuck flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= lvl;
    end
  end

  // Rise and fall are mutually exclusive because both derive from one synchronised bit.
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  // Measurement counter, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT;
      cnt        <= '0;
      hi_cnt     <= '0;
      high_out   <= '0;
      period_out <= '0;
      code_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // cnt == 1 on the cycle after a rise, so a width of N cycles reads back as N.
      if (rise) begin
        cnt <= {{CBITS{1'b0}}, 1'b1};
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      if (rise || fall) begin
        stuck_hi <= 1'b0;
        stuck_lo <= 1'b0;
        case (state)
          S_WAIT: begin
            // First rise only arms the measurement; a fall here is ignored.
            if (rise) state <= S_HIGH;
          end
          S_HIGH: begin
            if (fall) begin
              hi_cnt <= cnt;
              state  <= S_LOW;
            end
          end
          S_LOW: begin
            if (rise) begin
              period_out <= cnt;
              high_out   <= hi_cnt;
              code_out   <= hi_cnt[CBITS-2 -: CODE_BITS];
              locked     <= (cnt == NOMINAL) && (hi_cnt[CBITS -: 2] == 2'b00);
              meas_valid <= 1'b1;
              state      <= S_HIGH;
            end
          end
          default: state <= S_WAIT;
        endcase
      end else if (cnt == CNT_MAX) begin
        // No edge for a full saturated count: line is stuck; results hold, measurement re-arms.
        stuck_hi <= prev;
        stuck_lo <= ~prev;
        locked   <= 1'b0;
        state    <= S_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with a reduced counter width so full frames fit in a short run.
// Pin waveform is described as level segments; expected measurements come from segment lengths.
// Every strobe is scored against a queue of expected (high, period) pairs.
module tb_pwm_capture;

  localparam int CBITS     = 8;
  localparam int CODE_BITS = 3;
  localparam int MAXC      = (1 << (CBITS + 1)) - 1;
  localparam int NOM       = 1 << CBITS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 pulse_in;
  logic [CBITS:0]       high_out;
  logic [CBITS:0]       period_out;
  logic                 meas_valid;
  logic [CODE_BITS-1:0] code_out;
  logic                 locked;
  logic                 stuck_hi;
  logic                 stuck_lo;

  pwm_capture #(
    .CBITS     (CBITS),
    .CODE_BITS (CODE_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .high_out   (high_out),
    .period_out (period_out),
    .meas_valid (meas_valid),
    .code_out   (code_out),
    .locked     (locked),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int hi;
    int per;
  } meas_t;

  meas_t exp_q[$];

  // Reference model state: pin level, whether a rise has armed a measurement,
  // length of the last high phase and cycles since the last rise.
  bit armed   = 1'b0;
  bit lvl     = 1'b0;
  int hi_len  = 0;
  int cur_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cur_len++;
    end
  endtask

  // A rise closes the previous period if one was armed and no timeout intervened.
  task automatic set_pin(input bit v);
    if (v && !lvl) begin
      if (armed && cur_len <= MAXC) exp_q.push_back('{hi: hi_len, per: cur_len});
      armed   = 1'b1;
      cur_len = 0;
    end else if (!v && lvl) begin
      hi_len = cur_len;
    end
    lvl      = v;
    pulse_in = v;
  endtask

  task automatic seg(input bit v, input int n);
    set_pin(v);
    cyc(n);
  endtask

  task automatic frame(input int h, input int l);
    seg(1'b1, h);
    seg(1'b0, l);
  endtask

  function automatic int code_width(input int c);
    return (2 * c + 1) << (CBITS - 5);
  endfunction

  // Scoreboard: strobes must match queued expectations; no strobe when nothing is expected.
  always @(negedge clk) begin
    meas_t e;
    if (rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("no_spurious_strobe", meas_valid, 0);
      end else if (meas_valid === 1'b1) begin
        e = exp_q.pop_front();
        chk("sb_high_out", high_out, e.hi);
        chk("sb_period_out", period_out, e.per);
        chk("sb_code_out", code_out, (e.hi >> (CBITS - 4)) % 8);
        chk("sb_locked", locked, (e.per == NOM && e.hi < NOM / 2) ? 1 : 0);
      end
    end
  end

  initial begin
    int  n;
    bit  done;
    int  h;
    int  l;
    int  c;

    // Reset held for 5 cycles with the line low.
    rst      = 1'b1;
    pulse_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_meas_valid", meas_valid, 0);
    end
    chk("rst_high_out", high_out, 0);
    chk("rst_period_out", period_out, 0);
    chk("rst_code_out", code_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_stuck_hi", stuck_hi, 0);
    chk("rst_stuck_lo", stuck_lo, 0);
    rst = 1'b0;
    armed = 1'b0;
    cyc(20);

    // Nominal frames, code 5; first strobe only after the second rise.
    for (int i = 0; i < 3; i++) frame(code_width(5), NOM - code_width(5));
    set_pin(1'b1);
    cyc(10);
    chk("code5_high_out", high_out, 88);
    chk("code5_period_out", period_out, NOM);
    chk("code5_code_out", code_out, 5);
    chk("code5_locked", locked, 1);
    cyc(code_width(5) - 10);
    seg(1'b0, NOM - code_width(5));

    // Code 0 then code 7.
    frame(code_width(0), NOM - code_width(0));
    seg(1'b1, 10);
    chk("code0_high_out", high_out, 8);
    chk("code0_code_out", code_out, 0);
    chk("code0_locked", locked, 1);
    cyc(code_width(7) - 10);
    seg(1'b0, NOM - code_width(7));
    seg(1'b1, 10);
    chk("code7_high_out", high_out, 120);
    chk("code7_code_out", code_out, 7);
    chk("code7_locked", locked, 1);
    cyc(code_width(5) - 10);
    seg(1'b0, NOM - code_width(5));

    // Randomised frames: nominal code frames mixed with arbitrary widths within the counter range.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = $urandom_range(0, 7);
        h = code_width(c);
        l = NOM - h;
      end else begin
        h = $urandom_range(4, 250);
        l = $urandom_range(4, 250);
      end
      frame(h, l);
    end
    frame(code_width(5), NOM - code_width(5));
    frame(code_width(5), NOM - code_width(5));

    // Line stuck low after lock: flag rises MAXC cycles after the edge is seen (3 cycles after the pin).
    set_pin(1'b1);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 2 * MAXC && !done; i++) begin
      if (n == code_width(5)) set_pin(1'b0);
      cyc(1);
      n++;
      if (stuck_lo === 1'b1) done = 1'b1;
    end
    chk("stuck_lo_latency", n, MAXC + 3);
    chk("stuck_lo_locked", locked, 0);
    chk("stuck_lo_stuck_hi", stuck_hi, 0);
    chk("stuck_lo_hold_high", high_out, 88);
    chk("stuck_lo_hold_period", period_out, NOM);
    set_pin(1'b1);
    cyc(2);
    chk("stuck_lo_before_edge", stuck_lo, 1);
    cyc(1);
    chk("stuck_lo_cleared", stuck_lo, 0);
    cyc(code_width(5) - 3);
    seg(1'b0, NOM - code_width(5));
    frame(code_width(3), NOM - code_width(3));
    frame(code_width(3), NOM - code_width(3));

    // Line stuck high.
    set_pin(1'b1);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 2 * MAXC && !done; i++) begin
      cyc(1);
      n++;
      if (stuck_hi === 1'b1) done = 1'b1;
    end
    chk("stuck_hi_latency", n, MAXC + 3);
    chk("stuck_hi_locked", locked, 0);
    chk("stuck_hi_stuck_lo", stuck_lo, 0);
    seg(1'b0, 3);
    chk("stuck_hi_cleared", stuck_hi, 0);
    cyc(50);
    frame(code_width(2), NOM - code_width(2));
    frame(code_width(2), NOM - code_width(2));
    frame(code_width(2), NOM - code_width(2));

    // Reset in the middle of a high phase discards the partial measurement.
    set_pin(1'b1);
    cyc(30);
    rst = 1'b1;
    cyc(1);
    chk("midrst_high_out", high_out, 0);
    chk("midrst_period_out", period_out, 0);
    chk("midrst_code_out", code_out, 0);
    chk("midrst_meas_valid", meas_valid, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_stuck_hi", stuck_hi, 0);
    chk("midrst_stuck_lo", stuck_lo, 0);
    armed = 1'b0;
    set_pin(1'b0);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    for (int i = 0; i < 3; i++) frame(code_width(6), NOM - code_width(6));

`ifndef PWM_CAP_FILTER_EN
    // One-cycle glitch in the low phase is measured as a real pulse.
    seg(1'b1, code_width(6));
    seg(1'b0, 40);
    seg(1'b1, 1);
    seg(1'b0, NOM - code_width(6) - 41);
    seg(1'b1, 10);
    chk("glitch_high_out", high_out, 1);
    chk("glitch_period_out", period_out, NOM - code_width(6) - 40);
    chk("glitch_locked", locked, 0);
    cyc(code_width(6) - 10);
    seg(1'b0, NOM - code_width(6));
    frame(code_width(6), NOM - code_width(6));
`endif

    // Close the last period and make sure every expected strobe arrived.
    set_pin(1'b1);
    cyc(10);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
